sha1_msg_schedule: RTL and testbench



---
 rtl/sha1_pkg.sv | 19 +
 rtl/sha1_w_expand.sv | 15 +
 rtl/sha1_msg_schedule.sv | 133 +++++++++++++
 tb/tb_sha1_msg_schedule.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants, types and helpers for the SHA-1 message schedule.
package sha1_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int ROUNDS    = 80;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD,
    EMIT
  } state_e;

  function automatic word_t rotl1(input word_t x);
    return {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction

endpackage

// File: rtl/sha1_w_expand.sv
// sha1_w_expand: one SHA-1 schedule expansion step,
// rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
module sha1_w_expand
  import sha1_pkg::*;
(
  input  logic [WORD_W-1:0] w3_i,
  input  logic [WORD_W-1:0] w8_i,
  input  logic [WORD_W-1:0] w14_i,
  input  logic [WORD_W-1:0] w16_i,
  output logic [WORD_W-1:0] w_o
);

  assign w_o = rotl1(w3_i ^ w8_i ^ w14_i ^ w16_i);

endmodule

// File: rtl/sha1_msg_schedule.sv
// sha1_msg_schedule: loads 16 words, streams W[0..79] with in-place expansion.
// Define SHA1_SCHED_ZEROIZE_EN to clear the buffer after each block/abort/reset.
module sha1_msg_schedule
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [7:0]  w_idx,
  output logic        w_last,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  t_q, t_d;
  word_t       buf_q [BLK_WORDS];

  logic        wr_en;
  logic [3:0]  wr_idx;
  word_t       wr_data;
  logic [3:0]  i3, i8, i14, i16;
  word_t       exp_w, w_cur;
  logic        in_hs, w_hs, t_last;

  assign in_ready = (state_q == LOAD);
  assign w_valid  = (state_q == EMIT);
  assign in_hs    = in_valid && in_ready;
  assign w_hs     = w_valid && w_ready;
  assign t_last   = (t_q == 8'(ROUNDS - 1));

  // Circular slots of W[t-3], W[t-8], W[t-14], W[t-16].
  assign i3  = t_q[3:0] + 4'd13;
  assign i8  = t_q[3:0] + 4'd8;
  assign i14 = t_q[3:0] + 4'd2;
  assign i16 = t_q[3:0];

  sha1_w_expand u_expand (
    .w3_i  (buf_q[i3]),
    .w8_i  (buf_q[i8]),
    .w14_i (buf_q[i14]),
    .w16_i (buf_q[i16]),
    .w_o   (exp_w)
  );

  assign w_cur  = (t_q < 8'd16) ? buf_q[i16] : exp_w;
  assign w_word = w_valid ? w_cur : '0;
  assign w_idx  = t_q;
  assign w_last = w_valid && t_last;
  assign busy   = w_valid || (cnt_q != 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = in_word;
    if (abort) begin
      state_d = LOAD;
      cnt_d   = 4'd0;
      t_d     = 8'd0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_hs) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = EMIT;
              t_d     = 8'd0;
            end
          end
        end
        EMIT: begin
          if (w_hs) begin
            wr_en   = (t_q >= 8'd16);
            wr_idx  = i16;
            wr_data = w_cur;
            if (t_last) begin
              state_d = LOAD;
              cnt_d   = 4'd0;
              t_d     = 8'd0;
            end else begin
              t_d = t_q + 8'd1;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
    end
  end

`ifdef SHA1_SCHED_ZEROIZE_EN
  logic clr;

  // The clear wins over the final W[79] write-back.
  assign clr = abort || (w_hs && t_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_WORDS; i++) buf_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < BLK_WORDS; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= wr_data;
  end
`endif

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// tb_sha1_msg_schedule: directed checks of load, stream, stall, abort, reset.
// Expected W values come from a flat 80-word reference expansion.
module tb_sha1_msg_schedule;
  import sha1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_word;
  logic [7:0]  w_idx;
  logic        w_last;
  logic        busy;

  int    total = 0;
  int    bad = 0;
  word_t cur [16];
  word_t ew [80];
  word_t hand [4];

  always #5 clk = ~clk;

  sha1_msg_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    word_t x;
    for (int i = 0; i < 80; i++) begin
      if (i < 16) begin
        ew[i] = cur[i];
      end else begin
        x = ew[i-3] ^ ew[i-8] ^ ew[i-14] ^ ew[i-16];
        ew[i] = {x[30:0], x[31]};
      end
    end
  endtask

  task automatic use_abc();
    for (int i = 0; i < 16; i++) cur[i] = '0;
    cur[0]  = 32'h61626380;
    cur[15] = 32'h00000018;
    build_model();
  endtask

  task automatic use_b2();
    for (int i = 0; i < 16; i++)
      cur[i] = (32'h9E3779B9 * 32'(i + 1)) ^ {8'(i), 24'h5A5A5A};
    build_model();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_w_valid"},  {31'b0, w_valid},  32'd0);
    chk({tag, "_w_word"},   w_word,            32'd0);
    chk({tag, "_w_idx"},    {24'b0, w_idx},    32'd0);
    chk({tag, "_w_last"},   {31'b0, w_last},   32'd0);
    chk({tag, "_busy"},     {31'b0, busy},     32'd0);
  endtask

  task automatic chk_zero();
`ifdef SHA1_SCHED_ZEROIZE_EN
    for (int i = 0; i < 16; i++) chk("zeroize_buf", dut.buf_q[i], 32'd0);
`endif
  endtask

  task automatic load_block();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = cur[i];
      chk("load_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (i == 0) chk("load_busy", {31'b0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic emit_all(input bit rnd, input bit abc);
    int k = 0;
    int cyc = 0;
    while (k < 80 && cyc < 2000) begin
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("emit_w_valid",  {31'b0, w_valid},  32'd1);
      chk("emit_in_ready", {31'b0, in_ready}, 32'd0);
      chk("emit_w_idx",    {24'b0, w_idx},    32'(k));
      chk("emit_w_word",   w_word,            ew[k]);
      chk("emit_w_last",   {31'b0, w_last},   32'(k == 79));
      if (abc && k >= 16 && k < 20) chk("abc_hand_W", w_word, hand[k-16]);
      @(posedge clk); #1;
      if (w_ready) k++;
      cyc++;
    end
    w_ready = 1'b0;
    chk("emit_handshakes", 32'(k), 32'd80);
    chk("post_w_valid",  {31'b0, w_valid},  32'd0);
    chk("post_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_w_idx",    {24'b0, w_idx},    32'd0);
    chk("post_busy",     {31'b0, busy},     32'd0);
  endtask

  task automatic stream_to(input int n);
    for (int i = 0; i < n; i++) begin
      w_ready = 1'b1;
      @(posedge clk); #1;
    end
    w_ready = 1'b0;
    chk("stream_w_idx", {24'b0, w_idx}, 32'(n));
    chk("stream_w_word", w_word, ew[n]);
  endtask

  initial begin
    hand[0] = 32'hC2C4C700;
    hand[1] = 32'h00000000;
    hand[2] = 32'h00000030;
    hand[3] = 32'h85898E01;

    #12;
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_outs("reset_rel");

    use_abc();
    load_block();
    emit_all(1'b0, 1'b1);
    chk_zero();

    use_abc();
    load_block();
    emit_all(1'b1, 1'b1);

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_word  = 32'hFFFF0000 ^ 32'(i);
      @(posedge clk); #1;
    end
    chk("partial_busy", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_load_busy", {31'b0, busy}, 32'd0);
    chk("abort_load_ready", {31'b0, in_ready}, 32'd1);
    chk_zero();
    use_b2();
    load_block();
    emit_all(1'b0, 1'b0);

    use_abc();
    load_block();
    stream_to(40);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort40_w_valid",  {31'b0, w_valid},  32'd0);
    chk("abort40_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort40_w_idx",    {24'b0, w_idx},    32'd0);
    chk("abort40_busy",     {31'b0, busy},     32'd0);
    chk_zero();
    use_b2();
    load_block();
    emit_all(1'b1, 1'b0);

    use_abc();
    load_block();
    stream_to(25);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    chk_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;

    use_b2();
    load_block();
    emit_all(1'b0, 1'b0);
    chk_zero();
    use_abc();
    load_block();
    emit_all(1'b0, 1'b1);
    chk_zero();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
